// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch (ibus)
// and load/store (dbus). dbus wins on contention; define MEM_ARB_STARVE_EN
// to add a starvation guard that hands ibus the grant after MAX_WAIT denials.
module mem_arbiter #(
   parameter int unsigned AW       = 22,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ibus_req,
   input  logic [AW-1:0] ibus_addr,
   output logic          ibus_ready,
   output logic          ibus_rvalid,
   output logic [31:0]   ibus_rdata,
   input  logic          dbus_req,
   input  logic          dbus_we,
   input  logic [3:0]    dbus_wstrb,
   input  logic [AW-1:0] dbus_addr,
   input  logic [31:0]   dbus_wdata,
   output logic          dbus_ready,
   output logic          dbus_rvalid,
   output logic [31:0]   dbus_rdata,
   output logic          ram_en,
   output logic [3:0]    ram_we,
   output logic [AW-3:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   localparam int unsigned WAIT_W = 4;

   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_I    = 2'd1,
      RSP_D    = 2'd2
   } rsp_e;

   rsp_e rsp_q, rsp_d;
   logic grant_i_c, grant_d_c, starve_c;

   // Byte-lane address bits are dropped by the word-addressed RAM.
   logic unused_c;
   assign unused_c = ^{ibus_addr[1:0], dbus_addr[1:0], 4'(MAX_WAIT)};

`ifdef MEM_ARB_STARVE_EN
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   assign starve_c = (wait_cnt_q == WAIT_W'(MAX_WAIT));

   // Count consecutive contended cycles lost by ibus, saturating at MAX_WAIT.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!ibus_req || grant_i_c) begin
         wait_cnt_d = '0;
      end else if (grant_d_c && !starve_c) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign starve_c = 1'b0;
`endif

   // Grant selection: dbus first unless ibus has starved; nothing in reset.
   always_comb begin
      grant_i_c = 1'b0;
      grant_d_c = 1'b0;
      if (!rst) begin
         if (dbus_req && !(ibus_req && starve_c)) begin
            grant_d_c = 1'b1;
         end else if (ibus_req) begin
            grant_i_c = 1'b1;
         end
      end
   end

   // Drive the RAM port and handshakes from the winner.
   always_comb begin
      ibus_ready = grant_i_c;
      dbus_ready = grant_d_c;
      ram_en     = grant_i_c | grant_d_c;
      ram_addr   = grant_i_c ? ibus_addr[AW-1:2] : dbus_addr[AW-1:2];
      ram_we     = (grant_d_c && dbus_we) ? dbus_wstrb : 4'b0000;
      ram_wdata  = dbus_wdata;
   end

   // Response owner for the read issued this cycle.
   always_comb begin
      rsp_d = RSP_NONE;
      if (grant_i_c) begin
         rsp_d = RSP_I;
      end else if (grant_d_c && !dbus_we) begin
         rsp_d = RSP_D;
      end
   end

   // Response owner register; reset drops any pending response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_q <= RSP_NONE;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   // Read data goes to both buses; rvalid tells each one whether it is theirs.
   always_comb begin
      ibus_rvalid = (rsp_q == RSP_I);
      dbus_rvalid = (rsp_q == RSP_D);
      ibus_rdata  = ram_rdata;
      dbus_rdata  = ram_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural RAM,
// directed scenarios and randomized two-bus traffic.
module tb_mem_arbiter;

   localparam int unsigned AW       = 22;
   localparam int unsigned MAX_WAIT = 4;
`ifdef MEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic          clk, rst;
   logic          ibus_req;
   logic [AW-1:0] ibus_addr;
   logic          ibus_ready, ibus_rvalid;
   logic [31:0]   ibus_rdata;
   logic          dbus_req, dbus_we;
   logic [3:0]    dbus_wstrb;
   logic [AW-1:0] dbus_addr;
   logic [31:0]   dbus_wdata;
   logic          dbus_ready, dbus_rvalid;
   logic [31:0]   dbus_rdata;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-3:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;

   mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ready(dbus_ready),
      .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Behavioural RAM attached to the DUT's RAM port.
   logic [31:0] tb_ram  [0:4095];
   // Reference copy of memory contents, updated from the bench's own requests.
   logic [31:0] mdl_mem [0:4095];

   initial begin
      for (int i = 0; i < 4096; i++) begin
         tb_ram[i]  = $urandom;
         mdl_mem[i] = tb_ram[i];
      end
   end

   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= tb_ram[ram_addr[11:0]];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) tb_ram[ram_addr[11:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   typedef struct {
      logic [31:0] data;
      int          stamp;
   } exp_t;

   exp_t iq[$];
   exp_t dq[$];

   bit exp_gi, exp_gd;
   int denied = 0;

   // Reference model: decide the winner from the arbitration rules, check the
   // request-side outputs and queue the read data each bus should receive.
   always @(negedge clk) begin
      bit gi, gd, force_i;
      logic [11:0] wa;
      logic [3:0]  we_exp;
      if (rst) begin
         chk("rst_ibus_ready", 32'(ibus_ready), 32'd0);
         chk("rst_dbus_ready", 32'(dbus_ready), 32'd0);
         chk("rst_ram_en", 32'(ram_en), 32'd0);
         chk("rst_ram_we", 32'(ram_we), 32'd0);
         denied = 0;
         exp_gi = 1'b0;
         exp_gd = 1'b0;
      end else begin
         force_i = STARVE && (denied == int'(MAX_WAIT));
         gd = dbus_req && !(ibus_req && force_i);
         gi = ibus_req && !gd;
         we_exp = (gd && dbus_we) ? dbus_wstrb : 4'b0000;
         chk("ibus_ready", 32'(ibus_ready), 32'(gi));
         chk("dbus_ready", 32'(dbus_ready), 32'(gd));
         chk("ram_en", 32'(ram_en), 32'(gi | gd));
         chk("ram_we", 32'(ram_we), 32'(we_exp));
         if (gi) begin
            chk("ram_addr_i", 32'(ram_addr), 32'(ibus_addr >> 2));
            wa = ibus_addr[13:2];
            iq.push_back('{data: mdl_mem[wa], stamp: cyc});
         end
         if (gd) begin
            chk("ram_addr_d", 32'(ram_addr), 32'(dbus_addr >> 2));
            chk("ram_wdata", ram_wdata, dbus_wdata);
            wa = dbus_addr[13:2];
            if (dbus_we) begin
               for (int b = 0; b < 4; b++)
                  if (dbus_wstrb[b]) mdl_mem[wa][8*b +: 8] = dbus_wdata[8*b +: 8];
            end else begin
               dq.push_back('{data: mdl_mem[wa], stamp: cyc});
            end
         end
         if (ibus_req && gd) denied = (denied < int'(MAX_WAIT)) ? denied + 1 : denied;
         else denied = 0;
         exp_gi = gi;
         exp_gd = gd;
      end
   end

   // Response monitor: each rvalid must pair with the oldest queued read of
   // the previous cycle on that bus, and no rvalid may appear otherwise.
   always @(negedge clk) begin
      bit e_iv, e_dv;
      if (rst) begin
         chk("rst_ibus_rvalid", 32'(ibus_rvalid), 32'd0);
         chk("rst_dbus_rvalid", 32'(dbus_rvalid), 32'd0);
         iq.delete();
         dq.delete();
      end else begin
         e_iv = (iq.size() > 0) && (iq[0].stamp == cyc - 1);
         e_dv = (dq.size() > 0) && (dq[0].stamp == cyc - 1);
         chk("ibus_rvalid", 32'(ibus_rvalid), 32'(e_iv));
         chk("dbus_rvalid", 32'(dbus_rvalid), 32'(e_dv));
         if (ibus_rvalid && e_iv) chk("ibus_rdata", ibus_rdata, iq[0].data);
         if (dbus_rvalid && e_dv) chk("dbus_rdata", dbus_rdata, dq[0].data);
         while (iq.size() > 0 && iq[0].stamp < cyc) void'(iq.pop_front());
         while (dq.size() > 0 && dq[0].stamp < cyc) void'(dq.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ibus_req = 1'b0;
      dbus_req = 1'b0;
      dbus_we  = 1'b0;
   endtask

   initial begin
      logic [15:0] hi_before;
      rst        = 1'b1;
      ibus_req   = 1'b0;
      ibus_addr  = '0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_wstrb = 4'b0000;
      dbus_addr  = '0;
      dbus_wdata = '0;
      ram_rdata  = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Lone fetch read at 0x100 -> word 0x40.
      ibus_req  = 1'b1;
      ibus_addr = AW'(32'h100);
      step();
      idle();
      step();

      // Half-word write at 0x3FF0 -> word 0xFFC, then read it back.
      hi_before  = tb_ram[12'hFFC][31:16];
      dbus_req   = 1'b1;
      dbus_we    = 1'b1;
      dbus_wstrb = 4'b0011;
      dbus_addr  = AW'(32'h3FF0);
      dbus_wdata = 32'hDEADBEEF;
      step();
      idle();
      chk("ram_low_half", 32'(tb_ram[12'hFFC][15:0]), 32'h0000BEEF);
      chk("ram_high_half", 32'(tb_ram[12'hFFC][31:16]), 32'(hi_before));
      dbus_req  = 1'b1;
      dbus_addr = AW'(32'h3FF0);
      step();
      idle();
      step();

      // Zero-strobe write: accepted, no bytes written, no response.
      dbus_req   = 1'b1;
      dbus_we    = 1'b1;
      dbus_wstrb = 4'b0000;
      dbus_addr  = AW'(32'h0010);
      step();
      idle();
      step();

      // Both buses reading continuously, then dbus drops.
      ibus_req  = 1'b1;
      ibus_addr = AW'(32'h40);
      dbus_req  = 1'b1;
      dbus_we   = 1'b0;
      dbus_addr = AW'(32'h80);
      repeat (20) step();
      dbus_req = 1'b0;
      step();
      idle();
      step();

      // Alternating fetch at 0x0 and data read at 0x8.
      for (int k = 0; k < 8; k++) begin
         ibus_req  = (k % 2) == 0;
         ibus_addr = '0;
         dbus_req  = (k % 2) == 1;
         dbus_we   = 1'b0;
         dbus_addr = AW'(32'h8);
         step();
      end
      idle();
      step();

      // Reset in the cycle after a data read grant drops the response.
      dbus_req  = 1'b1;
      dbus_we   = 1'b0;
      dbus_addr = AW'(32'h20);
      step();
      idle();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();

      // Randomized traffic; requesters hold their request until accepted.
      for (int n = 0; n < 600; n++) begin
         if (!ibus_req || exp_gi) begin
            ibus_req  = $urandom_range(0, 99) < 70;
            ibus_addr = AW'($urandom_range(0, 16'h3FFF));
         end else if ($urandom_range(0, 99) < 5) begin
            ibus_req = 1'b0;
         end
         if (!dbus_req || exp_gd) begin
            dbus_req   = $urandom_range(0, 99) < 60;
            dbus_we    = $urandom_range(0, 1) == 1;
            dbus_wstrb = 4'($urandom_range(0, 15));
            dbus_addr  = AW'($urandom_range(0, 16'h3FFF));
            dbus_wdata = $urandom;
         end
         step();
      end
      idle();
      repeat (4) step();

      chk("ibus_q_drained", 32'(iq.size()), 32'd0);
      chk("dbus_q_drained", 32'(dq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the minisoc single-port RAM between the instruction fetch bus (ibus) and the load/store data bus (dbus). It sits between the core and the RAM, which holds both the program image and the data/signature area. It issues at most one RAM access per cycle and routes each read response to the requester that issued it. Data accesses have priority, and an optional starvation guard keeps fetch from being locked out.

## Interface
Parameters:
- `AW`, 22: byte address width; the RAM word address is `AW-2` bits.
- `MAX_WAIT`, 4: number of consecutive denied ibus cycles before ibus is forced to win; range 1..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ibus_req` in 1: fetch read request.
- `ibus_addr` in AW: fetch byte address; bits [1:0] are ignored.
- `ibus_ready` out 1: fetch request accepted this cycle.
- `ibus_rvalid` out 1: fetch read data valid.
- `ibus_rdata` out 32: fetch read data.
- `dbus_req` in 1: data request.
- `dbus_we` in 1: 1 = write, 0 = read.
- `dbus_wstrb` in 4: byte write strobes.
- `dbus_addr` in AW: data byte address.
- `dbus_wdata` in 32: write data.
- `dbus_ready` out 1: data request accepted this cycle.
- `dbus_rvalid` out 1: data read data valid.
- `dbus_rdata` out 32: data read data.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 4: RAM byte write enables.
- `ram_addr` out AW-2: RAM word address, equal to `addr[AW-1:2]`.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid 1 cycle after a read `ram_en`.

## Operation
- Grant is combinational each cycle:
  - Neither request: no grant.
  - One request: that requester wins.
  - Both requests: dbus wins, unless the starvation guard is active (`wait_cnt == MAX_WAIT`), in which case ibus wins.
- On grant:
  - `ready` = 1 to the winner only.
  - `ram_en` = 1.
  - `ram_addr` comes from the winner.
  - `ram_we` = `dbus_wstrb` if dbus is writing, else 0.
  - `ram_wdata` = `dbus_wdata`.
- A dbus write with `dbus_wstrb` = 0 is still accepted and drives `ram_en` = 1 with no bytes written. It produces no rvalid.
- Response owner FSM (registered), with states `RSP_NONE`, `RSP_I`, `RSP_D`:
  - Next state is `RSP_I` on an ibus grant.
  - Next state is `RSP_D` on a dbus read grant.
  - Otherwise (no grant or dbus write) next state is `RSP_NONE`.
  - Every state can go to every state each cycle, so responses are fully pipelined.
- Response outputs:
  - `ibus_rvalid` = (state == `RSP_I`).
  - `dbus_rvalid` = (state == `RSP_D`).
  - `ibus_rdata` = `dbus_rdata` = `ram_rdata`, unqualified.
- Starvation counter `wait_cnt` (4 bits):
  - Increments when ibus and dbus both request and dbus wins.
  - Clears when ibus is granted or `ibus_req` = 0.
  - Saturates at `MAX_WAIT`.
- Requesters hold address and data stable until they see `ready`. The arbiter does not buffer requests.

## Timing
- Request acceptance takes 0 cycles: `ready` and `ram_en` are asserted in the same cycle as the request.
- Read latency is 1 cycle: a read accepted in cycle N has its `rvalid` and data in cycle N+1.
- Throughput is 1 access per cycle. Back-to-back alternating ibus/dbus reads return in the same order, one per cycle.
- Reset values:
  - FSM = `RSP_NONE`, `wait_cnt` = 0.
  - All rvalid outputs, `ram_en` and `ram_we` are 0.
  - Combinational outputs follow their inputs, but every grant is forced to 0 while `rst` = 1.
- If reset is asserted while a read response is pending, the response is dropped: no `rvalid` appears after reset is released.
- A request that is dropped before `ready` is never issued to the RAM.

## Configuration
- `MEM_ARB_STARVE_EN` defined: the starvation counter is present and ibus is guaranteed a grant within `MAX_WAIT`+1 cycles of contention.
- `MEM_ARB_STARVE_EN` undefined: the counter is removed and dbus has strict priority, so ibus may wait indefinitely.

## Test plan
- ibus read at 0x100 alone: `ibus_ready` = 1 and `ram_addr` = 0x40 in the same cycle; next cycle `ibus_rvalid` = 1 and `ibus_rdata` = RAM[0x40].
- dbus write at 0x3FF0, `wstrb` = 0011, `wdata` = 0xDEADBEEF: `ram_we` = 0011 and `ram_addr` = 0xFFC; no rvalid follows; RAM[0xFFC] low half = 0xBEEF.
- Both buses reading continuously with `MAX_WAIT` = 4 (`MEM_ARB_STARVE_EN` defined): dbus is granted cycles 0-3, ibus in cycle 4, then the pattern repeats every 5 cycles.
- Same stimulus with `MEM_ARB_STARVE_EN` undefined: ibus gets no `ready` for 20 cycles; `ibus_ready` follows within 0 cycles of `dbus_req` dropping.
- Alternating ibus read 0x0 and dbus read 0x8 each cycle: each bus receives only its own data (RAM[0] and RAM[2] respectively), in order, with one rvalid per cycle.
- Reset asserted in the cycle after a dbus read grant: `dbus_rvalid` is 0 during and after reset, and the FSM is back in `RSP_NONE`.
